// File: rtl/mpaddsub_serial.sv
// Limb-serial multi-precision adder/subtractor: processes one WORD-bit limb per cycle,
// ripple carry/borrow held in a flop, result and zero flag registered at completion.
module mpaddsub_serial #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned WORD  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  input  logic             write,
  input  logic             start,
  output logic [WIDTH:0]   s_out,
  output logic             ready,
  output logic             busy,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / WORD;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((WORD == 0) || (WIDTH < WORD) || ((WIDTH % WORD) != 0)) begin : g_bad_params
    $error("mpaddsub_serial: WIDTH must be a non-zero multiple of WORD");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     carry_q, carry_d;
  logic                     zacc_q, zacc_d;
  logic                     sub_q, sub_d;
  logic [N-1:0][WORD-1:0]   a_q, a_d;
  logic [N-1:0][WORD-1:0]   b_q, b_d;
  logic [N-1:0][WORD-1:0]   s_q, s_d;
  logic                     top_q, top_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     zero_q, zero_d;

  logic [WORD-1:0]          b_limb_c;
  logic [WORD:0]            t_c;

  // One limb of the ripple: subtraction is A + ~B + 1, the +1 seeded as the initial carry
  always_comb begin
    b_limb_c = sub_q ? ~b_q[idx_q] : b_q[idx_q];
    t_c      = {1'b0, a_q[idx_q]} + {1'b0, b_limb_c} + (WORD+1)'(carry_q);
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    top_d   = top_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          carry_d = sub_q;
          zacc_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (write) begin
          a_d   = a_in;
          b_d   = b_in;
          sub_d = sub;
        end
      end
      RUN: begin
        s_d[idx_q] = t_c[WORD-1:0];
        carry_d    = t_c[WORD];
        zacc_d     = zacc_q & (t_c[WORD-1:0] == '0);
        if (idx_q == LAST_IDX) begin
          // Final carry out of A + ~B + 1 is the inverse of the borrow
          top_d   = sub_q ? ~t_c[WORD] : t_c[WORD];
          state_d = IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          zero_d  = zacc_d;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      top_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      top_q   <= top_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      zero_q  <= zero_d;
    end
  end

  assign s_out = {top_q, s_q};
  assign ready = ready_q;
  assign busy  = busy_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_mpaddsub_serial.sv
// Randomised self-checking bench for mpaddsub_serial in three geometries (N=8, N=1, N=3),
// checked against plain wide-integer add/subtract.
module tb_mpaddsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [255:0] a8, b8;
  logic         sub8, wr8, st8, rdy8, busy8, zero8;
  logic [256:0] s8;
  logic [63:0]  a1, b1;
  logic         sub1, wr1, st1, rdy1, busy1, zero1;
  logic [64:0]  s1;
  logic [95:0]  a3, b3;
  logic         sub3, wr3, st3, rdy3, busy3, zero3;
  logic [96:0]  s3;

  mpaddsub_serial #(.WIDTH(256), .WORD(32)) u8 (
    .CLK(clk), .RST(rst), .a_in(a8), .b_in(b8), .sub(sub8), .write(wr8), .start(st8),
    .s_out(s8), .ready(rdy8), .busy(busy8), .zero(zero8));
  mpaddsub_serial #(.WIDTH(64), .WORD(64)) u1 (
    .CLK(clk), .RST(rst), .a_in(a1), .b_in(b1), .sub(sub1), .write(wr1), .start(st1),
    .s_out(s1), .ready(rdy1), .busy(busy1), .zero(zero1));
  mpaddsub_serial #(.WIDTH(96), .WORD(32)) u3 (
    .CLK(clk), .RST(rst), .a_in(a3), .b_in(b3), .sub(sub3), .write(wr3), .start(st3),
    .s_out(s3), .ready(rdy3), .busy(busy3), .zero(zero3));

  // Reference: w-bit unsigned add with carry-out, or subtract mod 2^w with borrow-out
  function automatic logic [256:0] golden(input logic [255:0] a, input logic [255:0] b,
                                          input logic s, input int w);
    logic [256:0] m, r;
    m = (257'(1) << w) - 257'(1);
    if (!s) r = {1'b0, a} + {1'b0, b};
    else begin
      r    = ({1'b0, a} - {1'b0, b}) & m;
      r[w] = (a < b);
    end
    return r;
  endfunction

  function automatic logic [255:0] rnd(input int w);
    logic [255:0] v;
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) v = '0;
    else if (sel == 1) v = '1;
    else for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v & ((256'(1) << w) - 256'(1));
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [255:0] a, input logic [255:0] b, input logic s,
                      output int lat, output logic [256:0] res, output logic z, output int bc);
    a8 = a; b8 = b; sub8 = s; wr8 = 1'b1; st8 = 1'b0;
    step();
    wr8 = 1'b0; st8 = 1'b1;
    step();
    st8 = 1'b0;
    lat = -1;
    bc  = (busy8 === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rdy8 === 1'b1) begin lat = k; break; end
      if (busy8 === 1'b1) bc++;
    end
    res = s8; z = zero8;
  endtask

  task automatic run1(input logic [63:0] a, input logic [63:0] b, input logic s,
                      output int lat, output logic [64:0] res, output logic z);
    a1 = a; b1 = b; sub1 = s; wr1 = 1'b1; st1 = 1'b0;
    step();
    wr1 = 1'b0; st1 = 1'b1;
    step();
    st1 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rdy1 === 1'b1) begin lat = k; break; end
    end
    res = s1; z = zero1;
  endtask

  task automatic run3(input logic [95:0] a, input logic [95:0] b, input logic s,
                      output int lat, output logic [96:0] res, output logic z);
    a3 = a; b3 = b; sub3 = s; wr3 = 1'b1; st3 = 1'b0;
    step();
    wr3 = 1'b0; st3 = 1'b1;
    step();
    st3 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rdy3 === 1'b1) begin lat = k; break; end
    end
    res = s3; z = zero3;
  endtask

  task automatic test_reset;
    int lat;
    rst = 1'b1; a8 = '1; b8 = '1; sub8 = 1'b1; wr8 = 1'b1; st8 = 1'b1;
    step();
    step();
    rst = 1'b0; wr8 = 1'b0; st8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    tests++; if (s8 !== '0)     begin fails++; $display("FAIL reset_s_out: got %h want 0", s8); end
    tests++; if (rdy8 !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", rdy8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy8); end
    tests++; if (zero8 !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b want 0", zero8); end
    tests++; if (s1 !== '0 || s3 !== '0) begin fails++; $display("FAIL reset_small: got %h %h want 0", s1, s3); end
    // Start with no write after reset: operands must have been cleared despite write/start during reset
    st8 = 1'b1;
    step();
    st8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rdy8 === 1'b1) begin lat = k; break; end
    end
    tests++; if (lat != 8)     begin fails++; $display("FAIL first_start_latency: got %0d want 8", lat); end
    tests++; if (s8 !== '0)    begin fails++; $display("FAIL first_start_s_out: got %h want 0", s8); end
    tests++; if (zero8 !== 1'b1) begin fails++; $display("FAIL first_start_zero: got %b want 1", zero8); end
  endtask

  task automatic test_add_overflow;
    int lat, bc; logic [256:0] res; logic z;
    run8('1, 256'd1, 1'b0, lat, res, z, bc);
    tests++; if (lat != 8) begin fails++; $display("FAIL add_ovf_latency: got %0d want 8", lat); end
    tests++; if (res !== (257'(1) << 256)) begin fails++; $display("FAIL add_ovf_s_out: got %h want 1<<256", res); end
    tests++; if (z !== 1'b1) begin fails++; $display("FAIL add_ovf_zero: got %b want 1", z); end
    tests++; if (bc != 8) begin fails++; $display("FAIL add_ovf_busy_cycles: got %0d want 8", bc); end
    step();
    tests++; if (rdy8 !== 1'b0) begin fails++; $display("FAIL ready_one_cycle: got %b want 0", rdy8); end
  endtask

  task automatic test_sub;
    int lat, bc; logic [256:0] res; logic z;
    logic [255:0] gx;
    gx = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
    run8(256'd5, 256'd7, 1'b1, lat, res, z, bc);
    tests++; if (res !== {1'b1, {255{1'b1}}, 1'b0}) begin fails++; $display("FAIL sub_5_7_s_out: got %h want 1_fff..fe", res); end
    tests++; if (z !== 1'b0) begin fails++; $display("FAIL sub_5_7_zero: got %b want 0", z); end
    run8(gx, gx, 1'b1, lat, res, z, bc);
    tests++; if (res !== '0) begin fails++; $display("FAIL sub_equal_s_out: got %h want 0", res); end
    tests++; if (z !== 1'b1) begin fails++; $display("FAIL sub_equal_zero: got %b want 1", z); end
    tests++; if (lat != 8) begin fails++; $display("FAIL sub_equal_latency: got %0d want 8", lat); end
  endtask

  task automatic test_ignore_busy;
    logic [255:0] a, b; logic s; logic [256:0] exp; int lat, extra;
    a = rnd(256); b = rnd(256); s = 1'($urandom_range(0, 1));
    exp = golden(a, b, s, 256);
    a8 = a; b8 = b; sub8 = s; wr8 = 1'b1;
    step();
    wr8 = 1'b0; st8 = 1'b1;
    step();
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin a8 = ~a; b8 = rnd(256); sub8 = ~s; wr8 = 1'b1; st8 = 1'b1; end
      else begin wr8 = 1'b0; st8 = 1'b0; end
      step();
      if (rdy8 === 1'b1) begin lat = k; break; end
    end
    wr8 = 1'b0; st8 = 1'b0;
    tests++; if (lat != 8) begin fails++; $display("FAIL busy_ignore_latency: got %0d want 8", lat); end
    tests++; if (s8 !== exp) begin fails++; $display("FAIL busy_ignore_s_out: got %h want %h", s8, exp); end
    tests++; if (zero8 !== (exp[255:0] == '0)) begin fails++; $display("FAIL busy_ignore_zero: got %b want %b", zero8, exp[255:0] == '0); end
    extra = 0;
    for (int k = 0; k < 16; k++) begin step(); if (rdy8 === 1'b1) extra++; end
    tests++; if (extra != 0 || busy8 !== 1'b0) begin fails++; $display("FAIL busy_ignore_extra: got %0d ready busy=%b want 0 0", extra, busy8); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, extra; logic [256:0] res; logic z;
    a8 = rnd(256) | 256'd1; b8 = rnd(256); sub8 = 1'b0; wr8 = 1'b1;
    step();
    wr8 = 1'b0; st8 = 1'b1;
    step();
    st8 = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (s8 !== '0 || busy8 !== 1'b0 || rdy8 !== 1'b0) begin
      fails++; $display("FAIL mid_reset_state: got s=%h busy=%b ready=%b want 0 0 0", s8, busy8, rdy8); end
    extra = 0;
    for (int k = 0; k < 12; k++) begin step(); if (rdy8 === 1'b1) extra++; end
    tests++; if (extra != 0) begin fails++; $display("FAIL mid_reset_no_ready: got %0d want 0", extra); end
    run8(256'd1, 256'd1, 1'b0, lat, res, z, bc);
    tests++; if (lat != 8 || res !== 257'd2) begin fails++; $display("FAIL after_reset_op: got lat=%0d s=%h want 8 2", lat, res); end
  endtask

  task automatic test_back_to_back;
    logic [255:0] a, b; logic s; logic [256:0] exp; int lat;
    a = rnd(256); b = rnd(256); s = 1'($urandom_range(0, 1));
    exp = golden(a, b, s, 256);
    a8 = a; b8 = b; sub8 = s; wr8 = 1'b1;
    step();
    wr8 = 1'b0; st8 = 1'b1;
    step();
    for (int op = 0; op < 3; op++) begin
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        step();
        if (rdy8 === 1'b1) begin lat = k; break; end
      end
      if (op == 2) st8 = 1'b0;
      tests++; if (lat != 8 || s8 !== exp) begin
        fails++; $display("FAIL b2b_op%0d: got lat=%0d s=%h want 8 %h", op, lat, s8, exp); end
      if (op < 2) begin
        step();
        tests++; if (busy8 !== 1'b1 || rdy8 !== 1'b0) begin
          fails++; $display("FAIL b2b_restart%0d: got busy=%b ready=%b want 1 0", op, busy8, rdy8); end
      end
    end
    step();
  endtask

  task automatic test_random8;
    logic [255:0] a, b; logic s; logic [256:0] exp, res; logic z; int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      a = rnd(256); b = ($urandom_range(0, 7) == 0) ? a : rnd(256); s = 1'($urandom_range(0, 1));
      exp = golden(a, b, s, 256);
      run8(a, b, s, lat, res, z, bc);
      tests++; if (lat != 8 || res !== exp || z !== (exp[255:0] == '0)) begin
        fails++; $display("FAIL rand8_%0d: got lat=%0d s=%h z=%b want 8 %h %b", i, lat, res, z, exp, exp[255:0] == '0); end
    end
  endtask

  task automatic test_random_n1;
    logic [255:0] a, b; logic s; logic [256:0] exp; logic [64:0] res; logic z; int lat;
    for (int i = 0; i < 1000; i++) begin
      a = rnd(64); b = ($urandom_range(0, 7) == 0) ? a : rnd(64); s = 1'($urandom_range(0, 1));
      exp = golden(a, b, s, 64);
      run1(a[63:0], b[63:0], s, lat, res, z);
      tests++; if (lat != 1 || res !== exp[64:0] || z !== (exp[63:0] == '0)) begin
        fails++; $display("FAIL rand1_%0d: got lat=%0d s=%h z=%b want 1 %h %b", i, lat, res, z, exp[64:0], exp[63:0] == '0); end
    end
  endtask

  task automatic test_random_n3;
    logic [255:0] a, b; logic s; logic [256:0] exp; logic [96:0] res; logic z; int lat;
    for (int i = 0; i < 1000; i++) begin
      a = rnd(96); b = ($urandom_range(0, 7) == 0) ? a : rnd(96); s = 1'($urandom_range(0, 1));
      exp = golden(a, b, s, 96);
      run3(a[95:0], b[95:0], s, lat, res, z);
      tests++; if (lat != 3 || res !== exp[96:0] || z !== (exp[95:0] == '0)) begin
        fails++; $display("FAIL rand3_%0d: got lat=%0d s=%h z=%b want 3 %h %b", i, lat, res, z, exp[96:0], exp[95:0] == '0); end
    end
  endtask

  initial begin
    rst = 1'b1;
    a8 = '0; b8 = '0; sub8 = 1'b0; wr8 = 1'b0; st8 = 1'b0;
    a1 = '0; b1 = '0; sub1 = 1'b0; wr1 = 1'b0; st1 = 1'b0;
    a3 = '0; b3 = '0; sub3 = 1'b0; wr3 = 1'b0; st3 = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random8();
    test_random_n1();
    test_random_n3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mpaddsub_serial.md
MPADDSUB_SERIAL -- requirements
Module: mpaddsub_serial

Interface
REQ-001 SHALL: parameter WIDTH, default 256, operand width in bits.
REQ-002 SHALL: parameter WORD, default 32, limb width processed per cycle.
REQ-003 SHALL: WIDTH be an integer multiple of WORD; N = WIDTH/WORD, N >= 1; any other setting is a build-time error.
REQ-004 SHALL: CLK  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL: RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL: a_in  in  WIDTH  operand A.
REQ-007 SHALL: b_in  in  WIDTH  operand B.
REQ-008 SHALL: sub  in  1  mode, 0 = A+B, 1 = A-B; sampled with write.
REQ-009 SHALL: write  in  1  latch a_in, b_in, sub into internal registers.
REQ-010 SHALL: start  in  1  begin operation on latched operands.
REQ-011 SHALL: s_out  out  WIDTH+1  result; bit WIDTH = carry (add) or borrow (sub).
REQ-012 SHALL: ready  out  1  one-cycle pulse, result valid.
REQ-013 SHALL: busy  out  1  operation in progress.
REQ-014 SHALL: zero  out  1  low WIDTH result bits all zero, valid while ready is high and until next start.

Function
REQ-015 SHALL: FSM with two states, IDLE and RUN, plus limb index idx of ceil(log2(N)) bits (min 1).
REQ-016 SHALL: IDLE, write=1, start=0 -> latch a_in, b_in, sub at that edge.
REQ-017 SHALL: IDLE, start=1 -> enter RUN, idx=0, carry=sub, zero accumulator=1, busy=1 from next cycle; start has priority, write in the same cycle ignored.
REQ-018 SHALL: RUN per cycle: t = a[idx] + (sub ? ~b[idx] : b[idx]) + carry, WORD+1 bits; s_out limb idx <= t[WORD-1:0]; carry <= t[WORD]; zero accumulator ANDed with (t[WORD-1:0]==0); idx <= idx+1.
REQ-019 SHALL: on the edge processing limb N-1 -> s_out[WIDTH] <= sub ? ~carry_out : carry_out, state <= IDLE, busy <= 0, ready <= 1, zero <= final accumulator.
REQ-020 SHALL: latency exactly N cycles: start sampled at edge E0, ready high in the cycle after edge EN, for exactly one cycle.
REQ-021 SHALL: result for add = A+B (WIDTH+1 bits); for sub low bits = (A-B) mod 2^WIDTH, bit WIDTH = 1 iff A < B (unsigned).
REQ-022 SHALL: start and write while busy=1 are ignored; the running operation is unaffected.
REQ-023 SHALL: start asserted for multiple cycles in IDLE starts one operation per IDLE cycle sampled; a start held through completion restarts on the first cycle after ready (back-to-back, no gap beyond ready cycle).
REQ-024 SHALL: s_out limbs are updated progressively during RUN; s_out is valid only from ready until the next start.
REQ-025 SHALL: N=1 works: RUN lasts one cycle, idx constant 0.

Reset
REQ-026 SHALL: RST=1 at any edge, including mid-RUN -> state IDLE, idx 0, carry 0, s_out 0, ready 0, busy 0, zero 0, latched operands 0, sub 0; no ready pulse for the aborted operation.
REQ-027 SHALL: RST has priority over start and write in the same cycle.
REQ-028 SHALL: first start after reset release behave as a normal operation on operands written after release (or zeros if none written: result 0, zero=1).

Verification (WIDTH=256, WORD=32, N=8 unless stated)
REQ-029 SHALL: add A=2^256-1, B=1 -> ready 8 cycles after start, s_out = 1 followed by 256 zeros (bit 256 = 1), zero=1, busy high 8 cycles.
REQ-030 SHALL: sub A=5, B=7 -> s_out[255:0] = 2^256-2, s_out[256]=1, zero=0; sub A=B=0x6B17...C296 -> s_out=0, zero=1.
REQ-031 SHALL: write new operands and pulse start at cycle 3 of RUN -> both ignored, result matches original operands, no extra ready.
REQ-032 SHALL: RST pulse at cycle 4 of RUN -> s_out=0, busy=0, no ready; subsequent write+start of 0x1+0x1 -> s_out=2 after 8 cycles.
REQ-033 SHALL: 1000 LFSR-random operand pairs, random sub, back-to-back -> s_out and zero match golden ({0,A}+{0,B} or A-B with borrow) at every ready.
REQ-034 SHALL: repeat REQ-033 with WIDTH=64, WORD=64 (N=1, latency 1) and WIDTH=96, WORD=32 (N=3, latency 3).
